// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-control definitions: FSM encodings, redirect source codes, reset PC.
// Also holds the target-alignment helper used when a redirect is captured.
package fetch_ctrl_pkg;

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic SRC_BR   = 1'b0;
  localparam logic SRC_TRAP = 1'b1;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        vld;
    logic        src;
    logic [31:0] pc;
  } redir_t;

  // Bit 1 survives because compressed instructions are 2-byte aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0001;
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Redirect capture: trap beats branch, a pending trap blocks everything, a pending branch blocks branches.
// Latency: request visible on pend_* the next cycle; apply_i frees the entry so a same-cycle request refills it.
// Backpressure: none; requests that lose arbitration are dropped as wrong-path.
module redirect_arb
  import fetch_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  input  logic        br_req_i,
  input  logic [31:0] br_pc_i,
  input  logic        apply_i,
  output logic        pend_vld,
  output logic [31:0] pend_pc
);

  redir_t pend_q, pend_d;
  logic   hold_vld;

  // An entry being applied this cycle no longer blocks a new capture.
  assign hold_vld = pend_q.vld & ~apply_i;

  always_comb begin
    pend_d = pend_q;
    if (apply_i) begin
      pend_d.vld = 1'b0;
    end
    if (trap_req_i && !(hold_vld && (pend_q.src == SRC_TRAP))) begin
      pend_d = '{vld: 1'b1, src: SRC_TRAP, pc: align_pc(trap_pc_i)};
    end else if (br_req_i && !hold_vld) begin
      pend_d = '{vld: 1'b1, src: SRC_BR, pc: align_pc(br_pc_i)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '{vld: 1'b0, src: SRC_BR, pc: RESET_PC};
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_vld = pend_q.vld;
  assign pend_pc  = pend_q.pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing: START hold, RUN/HALTED FSM, redirect apply and decode flush window.
// Latency: redirect applied the cycle after its request; halt 1 cycle (2 with a redirect pending), resume 1 cycle.
// Backpressure: fet_en_o follows imem_ack_i & dec_ready_i except on an apply cycle, which always advances.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned RESET_HOLD  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        imem_ack_i,
  input  logic        dec_ready_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  input  logic        br_req_i,
  input  logic [31:0] br_pc_i,
  input  logic        halt_req_i,
  input  logic        resume_i,
  output logic        fet_en_o,
  output logic        fet_pc_update_o,
  output logic [31:0] fet_pc_o,
  output logic        flush_o,
  output logic        halted_o
);

  logic [1:0]  state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic [2:0]  flush_q, flush_d;
  logic        pend_vld;
  logic [31:0] pend_pc;
  logic        apply;

  assign apply = (state_q == ST_RUN) && pend_vld;

  redirect_arb u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .trap_req_i (trap_req_i),
    .trap_pc_i  (trap_pc_i),
    .br_req_i   (br_req_i),
    .br_pc_i    (br_pc_i),
    .apply_i    (apply),
    .pend_vld   (pend_vld),
    .pend_pc    (pend_pc)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_START: begin
        hold_d = hold_q - 4'd1;
        if (hold_d == 4'd0) state_d = ST_RUN;
      end
      // A pending redirect is applied before the halt is honoured.
      ST_RUN:    if (halt_req_i && !pend_vld) state_d = ST_HALTED;
      ST_HALTED: if (resume_i) state_d = ST_RUN;
      default:   state_d = ST_START;
    endcase
  end

  always_comb begin
    flush_d = flush_q;
    if (apply) begin
      flush_d = 3'(FLUSH_DEPTH - 1);
    end else if (flush_q != 3'd0) begin
      flush_d = flush_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_START;
      hold_q  <= 4'(RESET_HOLD);
      flush_q <= 3'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      flush_q <= flush_d;
    end
  end

  assign fet_en_o        = (state_q == ST_RUN) & (apply | (imem_ack_i & dec_ready_i));
  assign fet_pc_update_o = apply;
  assign fet_pc_o        = apply ? pend_pc : RESET_PC;
  assign flush_o         = apply | (flush_q != 3'd0);
  assign halted_o        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a behavioural model;
// expected redirects go into a scoreboard drained by an independent monitor.
module tb_fetch_ctrl;

  localparam int FD = 2;
  localparam int RH = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        imem_ack_i = 1'b0, dec_ready_i = 1'b0;
  logic        trap_req_i = 1'b0, br_req_i = 1'b0;
  logic [31:0] trap_pc_i = '0, br_pc_i = '0;
  logic        halt_req_i = 1'b0, resume_i = 1'b0;
  logic        fet_en_o, fet_pc_update_o, flush_o, halted_o;
  logic [31:0] fet_pc_o;

  fetch_ctrl #(.FLUSH_DEPTH(FD), .RESET_HOLD(RH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .imem_ack_i(imem_ack_i), .dec_ready_i(dec_ready_i),
    .trap_req_i(trap_req_i), .trap_pc_i(trap_pc_i), .br_req_i(br_req_i), .br_pc_i(br_pc_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i), .fet_en_o(fet_en_o),
    .fet_pc_update_o(fet_pc_update_o), .fet_pc_o(fet_pc_o), .flush_o(flush_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  // Model: mode 0=start 1=run 2=halted; pending redirect as {is_trap, target}.
  int          m_mode, m_hold, m_flush;
  logic [32:0] m_pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_fet_en"}, fet_en_o, 0);
    chk({tag, "_pc_update"}, fet_pc_update_o, 0);
    chk({tag, "_fet_pc"}, fet_pc_o, 0);
    chk({tag, "_flush"}, flush_o, 0);
    chk({tag, "_halted"}, halted_o, 0);
  endtask

  task automatic do_reset();
    #1;
    rst_ni = 1'b0;
    trap_req_i = 0; br_req_i = 0; halt_req_i = 0; resume_i = 0;
    imem_ack_i = 1; dec_ready_i = 1;
    m_mode = 0; m_hold = RH; m_flush = 0;
    m_pend.delete();
    sb.delete();
    #1;
    chk_idle_outputs("rst_async");
    @(posedge clk_i); @(posedge clk_i); #2;
    chk_idle_outputs("rst_held");
    rst_ni = 1'b1;
  endtask

  task automatic cycle(input bit ack, input bit rdy, input bit trap, input logic [31:0] tpc,
                       input bit br, input logic [31:0] bpc, input bit halt, input bit res);
    bit applying;
    @(negedge clk_i);
    cyc++;
    imem_ack_i = ack; dec_ready_i = rdy;
    trap_req_i = trap; trap_pc_i = tpc;
    br_req_i = br; br_pc_i = bpc;
    halt_req_i = halt; resume_i = res;
    #1;
    applying = (m_mode == 1) && (m_pend.size() != 0);
    chk("fet_en", fet_en_o, (m_mode == 1) && (applying || (ack && rdy)));
    chk("halted", halted_o, m_mode == 2);
    chk("flush", flush_o, applying || (m_flush != 0));
    if (applying) sb.push_back('{cyc, m_pend[0][31:0]});
    if (applying) begin
      m_pend.delete();
      m_flush = FD - 1;
    end else if (m_flush > 0) begin
      m_flush--;
    end
    if (trap) begin
      if (m_pend.size() == 0 || !m_pend[0][32]) begin
        m_pend.delete();
        m_pend.push_back({1'b1, tpc & ~32'h1});
      end
    end else if (br && m_pend.size() == 0) begin
      m_pend.push_back({1'b0, bpc & ~32'h1});
    end
    case (m_mode)
      0: begin m_hold--; if (m_hold == 0) m_mode = 1; end
      1: if (halt && !applying) m_mode = 2;
      default: if (res) m_mode = 1;
    endcase
  endtask

  task automatic idle(input int n, input bit ack, input bit rdy, input bit halt);
    for (int i = 0; i < n; i++) cycle(ack, rdy, 0, 0, 0, 0, halt, 0);
  endtask

  // Monitor: every redirect the DUT presents must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i); #2;
      if (!rst_ni) continue;
      if (fet_pc_update_o) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_apply cyc=%0d got pc=%h want no redirect", cyc, fet_pc_o);
        end else begin
          e = sb.pop_front();
          chk("apply_cycle", cyc, e.cyc);
          chk("fet_pc", fet_pc_o, e.pc);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        vectors++; miscompares++;
        $display("FAIL missing_apply cyc=%0d got no redirect want pc=%h", cyc, e.pc);
      end
    end
  end

  initial begin
    bit halt_lvl;
    do_reset();
    idle(4, 1, 1, 0);
    cycle(1, 1, 0, 0, 1, 32'h0000_0103, 0, 0);
    idle(4, 1, 1, 0);
    cycle(1, 1, 1, 32'h8000_0000, 1, 32'h0000_0200, 0, 0);
    idle(4, 1, 1, 0);
    // Halted with imem idle: branch captured, then replaced by a trap.
    cycle(0, 1, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 1, 32'h0000_0300, 1, 0);
    cycle(0, 1, 1, 32'h8000_0000, 0, 0, 1, 0);
    idle(2, 0, 1, 1);
    cycle(0, 1, 0, 0, 0, 0, 0, 1);
    idle(4, 1, 1, 0);
    // Halt raised while a branch is pending.
    cycle(1, 1, 0, 0, 1, 32'h0000_0446, 0, 0);
    idle(3, 1, 1, 1);
    cycle(1, 1, 0, 0, 0, 0, 0, 1);
    idle(1, 1, 0, 0);
    idle(2, 1, 1, 0);
    // Reset mid-flush with a refilled redirect pending.
    cycle(1, 1, 0, 0, 1, 32'h0000_0500, 0, 0);
    cycle(1, 1, 1, 32'h0000_0602, 0, 0, 0, 0);
    do_reset();
    idle(6, 1, 1, 0);
    halt_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) halt_lvl = ~halt_lvl;
      cycle($urandom_range(3) != 0, $urandom_range(3) != 0,
            $urandom_range(15) == 0, $urandom,
            $urandom_range(7) == 0, $urandom,
            halt_lvl, $urandom_range(9) == 0);
    end
    cycle(1, 1, 0, 0, 0, 0, 0, 1);
    idle(6, 1, 1, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
